// File: rtl/debounce_d.sv
// debounce_d: debouncer for a raw switch/button level.
//
// RawIn is brought into the Clock domain by a two-flop synchronizer. A
// two-state FSM then requires the synchronized level to differ from D at
// STABLE_CYCLES+1 consecutive edges before D is allowed to follow it.
//
// Parameters:
//   STABLE_CYCLES  stable counted cycles before D follows (1..2^CNT_WIDTH-1)
//   CNT_WIDTH      width of the stability counter
// Ports:
//   Clock   in   single clock, rising edge
//   Reset   in   synchronous active-low reset
//   RawIn   in   raw asynchronous level, may bounce
//   D       out  debounced registered level
//   Rise    out  one-cycle pulse when D goes 0->1
//   Fall    out  one-cycle pulse when D goes 1->0
//   Busy    out  high while a candidate change is being qualified
//
// Build option:
//   DEBOUNCE_EDGE_EN  defined   -> Rise/Fall are registered edge pulses
//                     undefined -> Rise/Fall tied to 0, no edge logic
//
// State | meaning
// IDLE  | synchronized input equals D, counter held at 0
// COUNT | synchronized input differs from D, counting stable cycles
module debounce_d #(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_WIDTH     = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic RawIn,
  output logic D,
  output logic Rise,
  output logic Fall,
  output logic Busy
);

  // The counter must be able to hold STABLE_CYCLES without wrapping.
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2 ** CNT_WIDTH) - 1) begin : g_bad_cfg
    $fatal(1, "debounce_d: STABLE_CYCLES must lie in 1..2^CNT_WIDTH-1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] STABLE_CNT = CNT_WIDTH'(STABLE_CYCLES);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 d_q, d_d;
  logic                 busy_q, busy_d;

  always_comb begin
    sync1_d = RawIn;
    sync2_d = sync1_q;
    state_d = state_q;
    count_d = count_q;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        if (sync2_q != d_q) begin
          state_d = COUNT;
          count_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          count_d = '0;
        end
      end
      COUNT: begin
        if (sync2_q == d_q) begin
          // Input reverted: drop the candidate, D untouched.
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == STABLE_CNT) begin
          state_d = IDLE;
          count_d = '0;
          d_d     = sync2_q;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    // Busy is registered from the next state so it lines up with state_q.
    busy_d = (state_d == COUNT);
  end

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = d_d & ~d_q;
    fall_d = ~d_d & d_q;
  end
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      count_q <= '0;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      count_q <= count_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
`ifdef DEBOUNCE_EDGE_EN
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`endif
    end
  end

  assign D    = d_q;
  assign Busy = busy_q;

`ifdef DEBOUNCE_EDGE_EN
  assign Rise = rise_q;
  assign Fall = fall_q;
`else
  assign Rise = 1'b0;
  assign Fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_d.sv
// Directed bench for debounce_d with STABLE_CYCLES=8.
// Ticks are numbered from the first edge that samples a newly driven input;
// outputs are sampled 1 time unit after each rising edge.
module tb_debounce_d;

  logic clk;
  logic rst_n;
  logic raw_in;
  logic d_out;
  logic rise;
  logic fall;
  logic busy;

  int checks   = 0;
  int failures = 0;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  debounce_d #(
    .STABLE_CYCLES(8),
    .CNT_WIDTH    (4)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .RawIn(raw_in),
    .D    (d_out),
    .Rise (rise),
    .Fall (fall),
    .Busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset held 3 edges with RawIn=1, then release: D=1 at tick 11.
  task automatic test_reset;
    logic [3:0] exp;
    rst_n  = 1'b0;
    raw_in = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if ({d_out, busy, rise, fall} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_hold t=%0d got {D,Busy,Rise,Fall}=%b want 0000", t, {d_out, busy, rise, fall});
      end
    end
    rst_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      exp = {t >= 11, (t >= 3 && t <= 10), EDGE_EN && t == 11, 1'b0};
      checks++;
      if ({d_out, busy, rise, fall} !== exp) begin
        failures++;
        $display("FAIL reset_release t=%0d got {D,Busy,Rise,Fall}=%b want %b", t, {d_out, busy, rise, fall}, exp);
      end
    end
  endtask

  // Clean step of RawIn to v from D=!v.
  task automatic test_step(input logic v);
    logic [3:0] exp;
    raw_in = v;
    for (int t = 1; t <= 12; t++) begin
      tick();
      exp = {(t >= 11) ? v : ~v, (t >= 3 && t <= 10),
             EDGE_EN && t == 11 && v, EDGE_EN && t == 11 && !v};
      checks++;
      if ({d_out, busy, rise, fall} !== exp) begin
        failures++;
        $display("FAIL step_%0b t=%0d got {D,Busy,Rise,Fall}=%b want %b", v, t, {d_out, busy, rise, fall}, exp);
      end
    end
  endtask

  // RawIn 1 x3, 0 x2, 1 x4, then 0; D stays 0.
  task automatic test_bounce;
    logic [3:0] exp;
    logic       exp_busy;
    for (int t = 1; t <= 25; t++) begin
      raw_in = (t <= 3) || (t >= 6 && t <= 9);
      tick();
      exp_busy = (t >= 3 && t <= 5) || (t >= 8 && t <= 11);
      exp = {1'b0, exp_busy, 1'b0, 1'b0};
      checks++;
      if ({d_out, busy, rise, fall} !== exp) begin
        failures++;
        $display("FAIL bounce t=%0d got {D,Busy,Rise,Fall}=%b want %b", t, {d_out, busy, rise, fall}, exp);
      end
    end
  endtask

  // A one-tick dip reaches the FSM exactly when count==8; qualification
  // restarts from 1 and D rises 9 ticks later.
  task automatic test_glitch_final;
    logic [3:0] exp;
    logic       exp_busy;
    for (int t = 1; t <= 22; t++) begin
      raw_in = (t != 9);
      tick();
      exp_busy = (t >= 3 && t <= 10) || (t >= 12 && t <= 19);
      exp = {t >= 20, exp_busy, EDGE_EN && t == 20, 1'b0};
      checks++;
      if ({d_out, busy, rise, fall} !== exp) begin
        failures++;
        $display("FAIL glitch_final t=%0d got {D,Busy,Rise,Fall}=%b want %b", t, {d_out, busy, rise, fall}, exp);
      end
    end
  endtask

  // Reset asserted with count==5; full qualification needed after release.
  task automatic test_reset_mid;
    logic [3:0] exp;
    raw_in = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp = {1'b0, t >= 3, 1'b0, 1'b0};
      checks++;
      if ({d_out, busy, rise, fall} !== exp) begin
        failures++;
        $display("FAIL reset_mid_pre t=%0d got {D,Busy,Rise,Fall}=%b want %b", t, {d_out, busy, rise, fall}, exp);
      end
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({d_out, busy, rise, fall} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_abort got {D,Busy,Rise,Fall}=%b want 0000", {d_out, busy, rise, fall});
    end
    rst_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      exp = {t >= 11, (t >= 3 && t <= 10), EDGE_EN && t == 11, 1'b0};
      checks++;
      if ({d_out, busy, rise, fall} !== exp) begin
        failures++;
        $display("FAIL reset_mid_post t=%0d got {D,Busy,Rise,Fall}=%b want %b", t, {d_out, busy, rise, fall}, exp);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    raw_in = 1'b0;
    test_reset();
    test_step(1'b0);
    test_step(1'b1);
    test_step(1'b0);
    test_bounce();
    test_glitch_final();
    test_step(1'b0);
    test_reset_mid();
    test_step(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_d.md
DEBOUNCE_D -- requirements
Module: debounce_d

Interface
REQ-001 Parameter STABLE_CYCLES, default 8, number of consecutive stable counted cycles required before D follows the input.
REQ-002 Parameter CNT_WIDTH, default 4, width of the stability counter.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset (Reset==0 sampled at a rising edge of Clock resets the block).
REQ-005 RawIn  input  1  raw asynchronous switch/button level; may bounce.
REQ-006 D  output  1  debounced registered level; drives the D input of the downstream latch stage.
REQ-007 Rise  output  1  one-cycle pulse when D goes 0->1.
REQ-008 Fall  output  1  one-cycle pulse when D goes 1->0.
REQ-009 Busy  output  1  high while a candidate change is being qualified (state COUNT).

Function
REQ-010 RawIn SHALL pass through a two-flop synchronizer (sync1 <= RawIn, sync2 <= sync1); only sync2 feeds the FSM.
REQ-011 FSM SHALL have exactly two states: IDLE (sync2 == D) and COUNT (qualifying sync2 != D).
REQ-012 IDLE: sync2 != D at an edge -> COUNT, count <= 1; otherwise stay IDLE with count held at 0.
REQ-013 COUNT, sync2 == D at an edge -> IDLE, count <= 0, D unchanged (glitch rejected, no pulse).
REQ-014 COUNT, sync2 != D, count < STABLE_CYCLES -> count <= count+1.
REQ-015 COUNT, sync2 != D, count == STABLE_CYCLES -> D <= sync2, count <= 0, IDLE.
REQ-016 Latency: with edge e0 the first edge at which sync1 captures a new RawIn level held stable thereafter, D SHALL update at edge e0+STABLE_CYCLES+2.
REQ-017 Any reversion of sync2 during COUNT, including at the edge where count == STABLE_CYCLES, SHALL abort qualification; qualification restarts from count 1 on the next mismatch.
REQ-018 Counter SHALL never wrap; STABLE_CYCLES outside 1..2^CNT_WIDTH-1 SHALL be an elaboration-time error (message plus simulation stop at time 0).
REQ-019 Busy SHALL equal (state == COUNT), registered, no extra latency.
REQ-020 D SHALL only change at rising edges of Clock and never toggle more than once per STABLE_CYCLES+1 cycles.

Reset
REQ-021 Reset==0 at a rising edge SHALL force sync1=0, sync2=0, D=0, count=0, state IDLE, Rise=0, Fall=0, Busy=0 after that edge.
REQ-022 Reset SHALL take priority over all other events, aborting any COUNT in progress without changing D to the candidate value.
REQ-023 After release, RawIn held at 1 SHALL produce D=1 after STABLE_CYCLES+2 edges, counting the first edge with Reset==1 as e0, with a Rise pulse.

Configuration
REQ-024 Macro DEBOUNCE_EDGE_EN defined: Rise/Fall SHALL be registered pulses high for exactly one clock cycle, beginning at the same edge where D changes (Rise for 0->1, Fall for 1->0).
REQ-025 Macro DEBOUNCE_EDGE_EN undefined: Rise and Fall ports SHALL remain present and be constant 0; no edge-detect logic is built.

Verification
REQ-026 Reset held low 3 edges, RawIn=1 -> D=0, Busy=0, Rise=0 throughout; release -> D=1 exactly 10 edges after release (STABLE_CYCLES=8), Rise=1 for 1 cycle (macro on).
REQ-027 Clean 0->1 step on RawIn, STABLE_CYCLES=8 -> Busy high edges e2..e9, D=1 at e10, Rise single pulse at e10, Fall stays 0.
REQ-028 Bounce: RawIn 1 for 3 cycles, 0 for 2, 1 for 4, 0 -> D stays 0, no Rise, Busy returns low after each reversion.
REQ-029 Glitch at final qualifying edge (sync2 reverts when count==8) -> D unchanged, count restarts, no pulse.
REQ-030 Reset asserted mid-COUNT (count==5) with D=0 -> after edge D=0, Busy=0, count=0; build without DEBOUNCE_EDGE_EN -> Rise=Fall=0 across all above scenarios.
